// File: rtl/write_back_regfile.sv
// Write-back register file: selects ALU/memory/PC data into regs[dr], tracks {N,Z,P}, commit pulse, error flag and count.
// Define WB_BYPASS_EN to make read ports return same-cycle write data (write-through).
module write_back_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable_writeback,
  input  logic [1:0]               W_Control,
  input  logic [DATA_W-1:0]        aluout,
  input  logic [DATA_W-1:0]        memout,
  input  logic [DATA_W-1:0]        pcout,
  input  logic [ADDR_W-1:0]        dr,
  input  logic [NUM_RD*ADDR_W-1:0] sr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [2:0]               psr,
  output logic                     wb_valid,
  output logic                     wb_err,
  output logic [15:0]              wr_count
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [2:0]        psr_q, psr_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_err_q, wb_err_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic [DATA_W-1:0] wb_data;
  logic              commit;

  function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] v);
    if (v[DATA_W-1])    return 3'b100;
    else if (v == '0)   return 3'b010;
    else                return 3'b001;
  endfunction

  always_comb begin
    wb_data = aluout;
    case (W_Control)
      2'd1:    wb_data = memout;
      2'd2:    wb_data = pcout;
      default: wb_data = aluout;
    endcase
  end

  // A reserved select never commits; it only raises the sticky error.
  assign commit = enable_writeback && (W_Control != 2'd3);

  always_comb begin
    psr_d      = psr_q;
    wr_count_d = wr_count_q;
    wb_err_d   = wb_err_q;
    wb_valid_d = commit;
    if (commit) begin
      psr_d      = nzp_of(wb_data);
      wr_count_d = wr_count_q + 16'd1;
    end
    if (enable_writeback && (W_Control == 2'd3)) wb_err_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      psr_q      <= 3'b010;
      wb_valid_q <= 1'b0;
      wb_err_q   <= 1'b0;
      wr_count_q <= 16'd0;
    end else begin
      if (commit) regs_q[dr] <= wb_data;
      psr_q      <= psr_d;
      wb_valid_q <= wb_valid_d;
      wb_err_q   <= wb_err_d;
      wr_count_q <= wr_count_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    assign idx = sr[k*ADDR_W +: ADDR_W];
`ifdef WB_BYPASS_EN
    assign rd_data[k*DATA_W +: DATA_W] = (commit && (idx == dr)) ? wb_data : regs_q[idx];
`else
    assign rd_data[k*DATA_W +: DATA_W] = regs_q[idx];
`endif
  end

  assign psr      = psr_q;
  assign wb_valid = wb_valid_q;
  assign wb_err   = wb_err_q;
  assign wr_count = wr_count_q;

endmodule
